// File: rtl/sap_pkg.sv
// Shared types for the SAP-1 control unit: opcodes,
// one-hot T-states and the control word bundle.
package sap_pkg;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } t_state_e;

   typedef struct packed {
      logic cp;
      logic ep;
      logic lm_n;
      logic ce_n;
      logic li_n;
      logic ei_n;
      logic la_n;
      logic ea;
      logic su;
      logic eu;
      logic lb_n;
      logic lo_n;
   } control_word_t;

   localparam control_word_t CW_NOP = '{
      cp:   1'b0,
      ep:   1'b0,
      lm_n: 1'b1,
      ce_n: 1'b1,
      li_n: 1'b1,
      ei_n: 1'b1,
      la_n: 1'b1,
      ea:   1'b0,
      su:   1'b0,
      eu:   1'b0,
      lb_n: 1'b1,
      lo_n: 1'b1
   };

endpackage

// File: rtl/sap_controller_sequencer_if.sv
// Opcode in, control word / T-state out between the
// sequencer (master) and the SAP-1 datapath (slave).
interface sap_controller_sequencer_if #(
   parameter int OPCODE_WIDTH = 4,
   parameter int T_STATES     = 6
);
   logic [OPCODE_WIDTH-1:0] opcode;
   logic                    cp;
   logic                    ep;
   logic                    lm_n;
   logic                    ce_n;
   logic                    li_n;
   logic                    ei_n;
   logic                    la_n;
   logic                    ea;
   logic                    su;
   logic                    eu;
   logic                    lb_n;
   logic                    lo_n;
   logic                    halt;
   logic [T_STATES-1:0]     t_state;

   modport master (
      input  opcode,
      output cp, ep, lm_n, ce_n, li_n, ei_n,
      output la_n, ea, su, eu, lb_n, lo_n,
      output halt, t_state
   );

   modport slave (
      output opcode,
      input  cp, ep, lm_n, ce_n, li_n, ei_n,
      input  la_n, ea, su, eu, lb_n, lo_n,
      input  halt, t_state
   );
endinterface

// File: rtl/sap_ring_counter.sv
// One-hot T1..T6 ring; freeze holds the current state,
// and any non-one-hot value recovers to T1.
module sap_ring_counter
   import sap_pkg::*;
(
   input  logic     clock,
   input  logic     reset,
   input  logic     advance,
   input  logic     freeze,
   output t_state_e state
);

   t_state_e state_next;

   always_ff @(posedge clock) begin
      if (reset) state <= T1;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (advance && !freeze) begin
         case (state)
            T1:      state_next = T2;
            T2:      state_next = T3;
            T3:      state_next = T4;
            T4:      state_next = T5;
            T5:      state_next = T6;
            T6:      state_next = T1;
            default: state_next = T1;
         endcase
      end
   end

endmodule

// File: rtl/sap_controller_sequencer.sv
// SAP-1 control unit: ring counter, opcode decoder and
// halt latch producing the per-T-state control word.
module sap_controller_sequencer
   import sap_pkg::*;
#(
   parameter int OPCODE_WIDTH = 4,
   parameter int T_STATES     = 6
) (
   input logic                        clock,
   input logic                        reset,
   sap_controller_sequencer_if.master bus
);

   if (T_STATES != 6 || OPCODE_WIDTH != 4) begin : g_bad_params
      $error("sap_controller_sequencer: only 4/6 supported");
   end

   t_state_e      ring;
   logic [5:0]    ring_bits;
   logic          halted;
   logic          hlt_t4;
   logic [3:0]    op;
   control_word_t cw;

   assign op        = bus.opcode;
   assign ring_bits = ring;
   assign hlt_t4    = !halted && (ring == T4)
                      && (op == OP_HLT);

   sap_ring_counter u_ring (
      .clock   (clock),
      .reset   (reset),
      .advance (1'b1),
      .freeze  (halted | hlt_t4),
      .state   (ring)
   );

   always_ff @(posedge clock) begin
      if (reset)       halted <= 1'b0;
      else if (hlt_t4) halted <= 1'b1;
   end

   always_comb begin
      cw = CW_NOP;
      if (!reset && !halted) begin
         unique case (1'b1)
            ring_bits[0]: begin
               cw.ep   = 1'b1;
               cw.lm_n = 1'b0;
            end
            ring_bits[1]: cw.cp = 1'b1;
            ring_bits[2]: begin
               cw.ce_n = 1'b0;
               cw.li_n = 1'b0;
            end
            ring_bits[3]: begin
               case (op)
                  OP_LDA, OP_ADD, OP_SUB: begin
                     cw.ei_n = 1'b0;
                     cw.lm_n = 1'b0;
                  end
                  OP_OUT: begin
                     cw.ea   = 1'b1;
                     cw.lo_n = 1'b0;
                  end
                  default: ;
               endcase
            end
            ring_bits[4]: begin
               case (op)
                  OP_LDA: begin
                     cw.ce_n = 1'b0;
                     cw.la_n = 1'b0;
                  end
                  OP_ADD, OP_SUB: begin
                     cw.ce_n = 1'b0;
                     cw.lb_n = 1'b0;
                  end
                  default: ;
               endcase
            end
            ring_bits[5]: begin
               if (op == OP_ADD || op == OP_SUB) begin
                  cw.eu   = 1'b1;
                  cw.la_n = 1'b0;
                  cw.su   = (op == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.cp      = cw.cp;
   assign bus.ep      = cw.ep;
   assign bus.lm_n    = cw.lm_n;
   assign bus.ce_n    = cw.ce_n;
   assign bus.li_n    = cw.li_n;
   assign bus.ei_n    = cw.ei_n;
   assign bus.la_n    = cw.la_n;
   assign bus.ea      = cw.ea;
   assign bus.su      = cw.su;
   assign bus.eu      = cw.eu;
   assign bus.lb_n    = cw.lb_n;
   assign bus.lo_n    = cw.lo_n;
   assign bus.halt    = halted & ~reset;
   assign bus.t_state = ring_bits;

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Directed bench for the SAP-1 sequencer; control word is
// {cp,ep,lm_n,ce_n,li_n,ei_n,la_n,ea,su,eu,lb_n,lo_n}.
module tb_sap_controller_sequencer;

   localparam logic [11:0] W_NOP  = 12'h3E3;
   localparam logic [11:0] W_T1   = 12'h5E3;
   localparam logic [11:0] W_T2   = 12'hBE3;
   localparam logic [11:0] W_T3   = 12'h263;
   localparam logic [11:0] W_T4M  = 12'h1A3;
   localparam logic [11:0] W_LDA5 = 12'h2C3;
   localparam logic [11:0] W_ADD5 = 12'h2E1;
   localparam logic [11:0] W_ADD6 = 12'h3C7;
   localparam logic [11:0] W_SUB6 = 12'h3CF;
   localparam logic [11:0] W_OUT4 = 12'h3F2;

   logic clock;
   logic reset;
   int   total;
   int   bad;

   sap_controller_sequencer_if #(
      .OPCODE_WIDTH (4),
      .T_STATES     (6)
   ) bif ();

   sap_controller_sequencer #(
      .OPCODE_WIDTH (4),
      .T_STATES     (6)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bif)
   );

   logic [11:0] cw;
   assign cw = {bif.cp, bif.ep, bif.lm_n, bif.ce_n,
                bif.li_n, bif.ei_n, bif.la_n, bif.ea,
                bif.su, bif.eu, bif.lb_n, bif.lo_n};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Bus drivers and ring encoding, checked every cycle.
   always @(negedge clock) begin
      int drv;
      drv = int'(bif.ep) + int'(!bif.ce_n)
            + int'(!bif.ei_n) + int'(bif.ea) + int'(bif.eu);
      total++;
      if (drv > 1 || !$onehot(bif.t_state)) begin
         bad++;
         $display("FAIL invariant drivers=%0d t_state=%h need <=1 and one-hot",
                  drv, bif.t_state);
      end
   end

   task automatic run_instr(input logic [3:0] op,
                            input logic [11:0] w4,
                            input logic [11:0] w5,
                            input logic [11:0] w6);
      logic [11:0] exp_w [6];
      logic [5:0]  exp_t;
      exp_w = '{W_T1, W_T2, W_T3, w4, w5, w6};
      bif.opcode = op;
      #1;
      for (int i = 0; i < 6; i++) begin
         exp_t = 6'b000001 << i;
         total++;
         if (bif.t_state !== exp_t) begin
            bad++;
            $display("FAIL op%h_tstate%0d got=%h exp=%h",
                     op, i + 1, bif.t_state, exp_t);
         end
         total++;
         if (cw !== exp_w[i] || bif.halt !== 1'b0) begin
            bad++;
            $display("FAIL op%h_cw_T%0d got=%h halt=%b exp=%h halt=0",
                     op, i + 1, cw, bif.halt, exp_w[i]);
         end
         tick();
      end
      total++;
      if (bif.t_state !== 6'h01) begin
         bad++;
         $display("FAIL op%h_wrap got=%h exp=01", op, bif.t_state);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bif.opcode = 4'h0;
      tick();
      tick();
      total++;
      if (bif.t_state !== 6'h01 || cw !== W_NOP
          || bif.halt !== 1'b0) begin
         bad++;
         $display("FAIL reset_state t=%h cw=%h halt=%b exp t=01 cw=%h halt=0",
                  bif.t_state, cw, bif.halt, W_NOP);
      end
      reset = 1'b0;
   endtask

   task automatic test_lda();
      run_instr(4'h0, W_T4M, W_LDA5, W_NOP);
   endtask

   task automatic test_add_sub();
      run_instr(4'h2, W_T4M, W_ADD5, W_SUB6);
      run_instr(4'h1, W_T4M, W_ADD5, W_ADD6);
   endtask

   task automatic test_out();
      run_instr(4'hE, W_OUT4, W_NOP, W_NOP);
   endtask

   task automatic test_unknown();
      run_instr(4'h7, W_NOP, W_NOP, W_NOP);
   endtask

   task automatic test_halt();
      bif.opcode = 4'hF;
      tick();
      tick();
      tick();
      total++;
      if (bif.t_state !== 6'h08 || cw !== W_NOP
          || bif.halt !== 1'b0) begin
         bad++;
         $display("FAIL hlt_T4 t=%h cw=%h halt=%b exp t=08 cw=%h halt=0",
                  bif.t_state, cw, bif.halt, W_NOP);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         bif.opcode = 4'(i);
         #1;
         total++;
         if (bif.t_state !== 6'h08 || cw !== W_NOP
             || bif.halt !== 1'b1) begin
            bad++;
            $display("FAIL halted_%0d t=%h cw=%h halt=%b exp t=08 cw=%h halt=1",
                     i, bif.t_state, cw, bif.halt, W_NOP);
         end
      end
      reset = 1'b1;
      #1;
      total++;
      if (bif.halt !== 1'b0 || cw !== W_NOP) begin
         bad++;
         $display("FAIL hlt_reset_comb halt=%b cw=%h exp halt=0 cw=%h",
                  bif.halt, cw, W_NOP);
      end
      tick();
      reset = 1'b0;
      bif.opcode = 4'h0;
      #1;
      total++;
      if (bif.t_state !== 6'h01 || bif.halt !== 1'b0
          || cw !== W_T1) begin
         bad++;
         $display("FAIL hlt_exit t=%h halt=%b cw=%h exp t=01 halt=0 cw=%h",
                  bif.t_state, bif.halt, cw, W_T1);
      end
   endtask

   task automatic test_reset_mid();
      bif.opcode = 4'h1;
      for (int i = 0; i < 4; i++) tick();
      total++;
      if (bif.t_state !== 6'h10 || cw !== W_ADD5) begin
         bad++;
         $display("FAIL mid_T5 t=%h cw=%h exp t=10 cw=%h",
                  bif.t_state, cw, W_ADD5);
      end
      reset = 1'b1;
      #1;
      total++;
      if (cw !== W_NOP) begin
         bad++;
         $display("FAIL mid_reset_nop cw=%h exp=%h", cw, W_NOP);
      end
      tick();
      total++;
      if (cw !== W_NOP || bif.t_state !== 6'h01) begin
         bad++;
         $display("FAIL mid_reset_held cw=%h t=%h exp cw=%h t=01",
                  cw, bif.t_state, W_NOP);
      end
      reset = 1'b0;
      #1;
      total++;
      if (bif.t_state !== 6'h01 || cw !== W_T1) begin
         bad++;
         $display("FAIL mid_restart t=%h cw=%h exp t=01 cw=%h",
                  bif.t_state, cw, W_T1);
      end
      tick();
      total++;
      if (bif.t_state !== 6'h02 || cw !== W_T2) begin
         bad++;
         $display("FAIL mid_restart_T2 t=%h cw=%h exp t=02 cw=%h",
                  bif.t_state, cw, W_T2);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bif.opcode = 4'h0;
      test_reset();
      test_lda();
      test_add_sub();
      test_out();
      test_unknown();
      test_halt();
      test_reset_mid();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
